// File: rtl/shift_by_reg_sequencer_pkg.sv
// rtl/shift_by_reg_sequencer_pkg.sv - shared encodings for the shift-by-register sequencer
package shift_by_reg_sequencer_pkg;

    localparam int REM_W         = 5;
    localparam int DEF_MAX_SHIFT = 16;

    // Extend_Shift_Unit source select
    localparam logic [1:0] SRC_IR3_0   = 2'b00;
    localparam logic [1:0] SRC_IR7_0   = 2'b01;
    localparam logic [1:0] SRC_REG_A   = 2'b10;
    localparam logic [1:0] SRC_ALU_OUT = 2'b11;

    // Extend_Shift_Unit amount select
    localparam logic [1:0] AMT_ONE   = 2'b00;
    localparam logic [1:0] AMT_IR3_0 = 2'b01;
    localparam logic [1:0] AMT_ZERO  = 2'b10;
    localparam logic [1:0] AMT_FOUR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FIRST = 2'b01,
        ST_STEP  = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shift_by_reg_sequencer_pass_planner.sv
// rtl/shift_by_reg_sequencer_pass_planner.sv - picks the next pass (4, 1 or 0) from the remaining count
module shift_pass_planner
    import shift_by_reg_sequencer_pkg::*;
(
    input  logic [REM_W-1:0] rem,
    output logic [1:0]       amt_sel,
    output logic [REM_W-1:0] rem_next,
    output logic             last_pass
);

    always_comb begin
        amt_sel  = AMT_ZERO;
        rem_next = '0;
        if (rem >= REM_W'(4)) begin
            amt_sel  = AMT_FOUR;
            rem_next = rem - REM_W'(4);
        end else if (rem != '0) begin
            amt_sel  = AMT_ONE;
            rem_next = rem - REM_W'(1);
        end
        last_pass = (rem_next == '0);
    end

endmodule

// File: rtl/shift_by_reg_sequencer.sv
// rtl/shift_by_reg_sequencer.sv - multi-pass shift-by-register controller for Extend_Shift_Unit
module shift_by_reg_sequencer
    import shift_by_reg_sequencer_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int AMT_W     = 16,
    parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             Start,
    input  logic             Left,
    input  logic [AMT_W-1:0] Amount,
    input  logic [WIDTH-1:0] ShiftIn,
    output logic [1:0]       ShifterInput,
    output logic             ShifterLeft,
    output logic [1:0]       ShiftAmount,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_load;
    logic             left_q;
    logic [WIDTH-1:0] result_q;
    logic             load;

    logic [1:0]       plan_amt;
    logic [REM_W-1:0] plan_rem_next;
    logic             plan_last;

    shift_pass_planner u_planner (
        .rem       (rem_q),
        .amt_sel   (plan_amt),
        .rem_next  (plan_rem_next),
        .last_pass (plan_last)
    );

    // Anything at or beyond the clamp behaves like a full-width shift.
    always_comb begin
        if (Amount >= AMT_W'(MAX_SHIFT)) begin
            rem_load = REM_W'(MAX_SHIFT);
        end else begin
            rem_load = Amount[REM_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        Busy         = 1'b0;
        Done         = 1'b0;
        ShifterInput = SRC_IR3_0;
        ShifterLeft  = 1'b0;
        ShiftAmount  = AMT_ZERO;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    load    = 1'b1;
                    state_d = ST_FIRST;
                end
            end
            ST_FIRST, ST_STEP: begin
                Busy         = 1'b1;
                ShifterInput = (state_q == ST_FIRST) ? SRC_REG_A : SRC_ALU_OUT;
                ShifterLeft  = left_q;
                ShiftAmount  = plan_amt;
                state_d      = plan_last ? ST_DONE : ST_STEP;
            end
            ST_DONE: begin
                Done = 1'b1;
                if (Start) begin
                    load    = 1'b1;
                    state_d = ST_FIRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Later passes recirculate Result through the unit's ALUOut input.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            rem_q    <= '0;
            left_q   <= 1'b0;
            result_q <= '0;
        end else if (load) begin
            rem_q  <= rem_load;
            left_q <= Left;
        end else if (Busy) begin
            rem_q    <= plan_rem_next;
            result_q <= ShiftIn;
        end
    end

    assign Result = result_q;

endmodule

// File: doc/shift_by_reg_sequencer.md
Name: shift_by_reg_sequencer

Overview:
Multi-cycle controller that runs shift-by-register instructions (amount taken from a register value, 0..65535) on the existing Extend_Shift_Unit. The unit itself only supports amounts of 0, 1, 4 or IR3_0. This block splits the shift into passes of 4 and 1. The first pass reads Reg_A; later passes feed the block's own Result back through the shift unit's ALUOut input. It sits beside the main control FSM, which starts it and stalls until Done.

Parameters:
WIDTH, 16, datapath width (must match Extend_Shift_Unit)
AMT_W, 16, width of the Amount input
MAX_SHIFT, 16, clamp value for Amount (a shift by >= WIDTH saturates)

Ports:
CLK  in  1  system clock, rising edge
Reset_L  in  1  asynchronous active-low reset
Start  in  1  request, 1-cycle strobe; sampled only when not Busy
Left  in  1  1 = logical left, 0 = arithmetic right; latched at Start
Amount  in  AMT_W  shift count; latched at Start
ShiftIn  in  WIDTH  Extend_Shift_Unit O output
ShifterInput  out  2  source select to shift unit
ShifterLeft  out  1  direction to shift unit
ShiftAmount  out  2  amount select to shift unit
Result  out  WIDTH  registered result; also wired to the shift unit's ALUOut input
Busy  out  1  a pass is in progress
Done  out  1  1-cycle pulse; Result is valid

Behaviour:
- Encodings. ShifterInput: 00 = IR3_0, 01 = IR7_0, 10 = Reg_A, 11 = ALUOut. ShiftAmount: 00 = const 1, 01 = IR3_0, 10 = const 0, 11 = const 4.
- Reset (async, Reset_L = 0):
  - State goes to IDLE.
  - Busy = 0, Done = 0, Result = 0, remaining counter = 0.
  - ShifterInput = 00, ShifterLeft = 0, ShiftAmount = 10.
  - Reset mid-operation aborts the shift immediately, with no Done.
- States: IDLE, FIRST, STEP, DONE.
- IDLE, or DONE with Start = 1: latch Left and rem = min(Amount, MAX_SHIFT) (5 bits), then go to FIRST.
- FIRST: ShifterInput = 10 (Reg_A). STEP: ShifterInput = 11 (ALUOut = Result).
- Amount select per pass:
  - rem >= 4: ShiftAmount = 11, rem -= 4.
  - 1 <= rem <= 3: ShiftAmount = 00, rem -= 1.
  - rem = 0 (FIRST only): ShiftAmount = 10.
- ShifterLeft = latched Left during FIRST and STEP; 0 otherwise.
- Every pass captures ShiftIn into Result at the end of the cycle.
- After a pass, go to DONE if the updated rem = 0, else to STEP.
- DONE lasts 1 cycle with Done = 1. Then go to IDLE, or to FIRST if Start = 1 (back-to-back).
- Busy = 1 exactly in FIRST and STEP. Start while Busy is ignored, not queued.
- Pass count P = max(1, n/4 + n%4), where n = clamped amount.
- Timing for Start sampled at edge k: passes occupy cycles k+1..k+P, Done is high in cycle k+P+1, Result holds until the next FIRST.
- Outside FIRST/STEP the shift-unit controls hold the neutral reset values.
- Reg_A must be stable during the FIRST cycle only.
- Amount >= 16: 4 passes of 4. Left gives 0; right gives sign fill, via the unit's arithmetic behaviour.

Decomposition:
- Shared header shift_seq_defs.vh holds: source-select and amount-select localparams (values above), state encodings, and MAX_SHIFT.
- One natural sub-module: shift_pass_planner. It is combinational; it maps (rem, first) to (ShiftAmount, next rem, last_pass).
- The FSM, latches and Result register stay in the top.

Test Plan:
1. Left = 1, Reg_A = 0x1111, Amount = 5, Start at k -> ShiftAmount sequence 11, 00; Busy during k+1..k+2; Done at k+3; Result = 0x2220.
2. Left = 0, Reg_A = 0x8001, Amount = 6 -> passes 11, 00, 00; Done at k+4; Result = 0xFE00.
3. Amount = 0, Reg_A = 0xABCD -> one pass with ShiftAmount = 10, ShifterInput = 10; Done at k+2; Result = 0xABCD.
4. Amount = 0x0100: Left with Reg_A = 0xFFFF -> 4 passes of 11, Result = 0x0000. Right with Reg_A = 0x8000 -> Result = 0xFFFF.
5. Start pulsed while Busy (Amount = 15, 6 passes) -> ignored, Done once at k+7. Start asserted in the Done cycle -> new FIRST at k+8.
6. Reset_L low after 2 passes of Amount = 15 -> Busy = 0, Done = 0, Result = 0 at once, no Done pulse. After release, Start with Amount = 1 completes normally at k+2.
